// File: rtl/neuron_sched_if.sv
// Request/result channel between the neuron scheduler and the shared
// neuron-update datapath. One request may be outstanding at a time.
interface neuron_sched_if #(
    parameter int N = 8,
    parameter int W = 16
);
    localparam int AW = $clog2(N);

    logic                dp_valid;
    logic                dp_ready;
    logic [AW-1:0]       dp_idx;
    logic signed [W-1:0] dp_v;
    logic signed [W-1:0] dp_i;
    logic                res_valid;
    logic signed [W-1:0] res_v;

    modport master (
        output dp_valid, dp_idx, dp_v, dp_i,
        input  dp_ready, res_valid, res_v
    );

    modport slave (
        input  dp_valid, dp_idx, dp_v, dp_i,
        output dp_ready, res_valid, res_v
    );
endinterface

// File: rtl/neuron_sched.sv
// Time-multiplexes N leaky neurons onto one external update datapath: each
// timestep sweeps every neuron, applying threshold/spike/refractory rules.
module neuron_sched #(
    parameter int                  N       = 8,
    parameter int                  W       = 16,
    parameter logic signed [W-1:0] V_INIT  = W'(-18074),
    parameter logic signed [W-1:0] V_TH    = W'(5120),
    parameter logic signed [W-1:0] V_RESET = W'(-18074),
    parameter logic [3:0]          REFRAC  = 4'd2,
    localparam int                 AW      = $clog2(N)
) (
    input  logic                emu_clk,
    input  logic                emu_rst_n,
    input  logic                step_start,
    input  logic                in_we,
    input  logic [AW-1:0]       in_addr,
    input  logic signed [W-1:0] in_data,
    neuron_sched_if.master      dp,
    output logic                spike_valid,
    output logic [AW-1:0]       spike_idx,
    output logic                busy,
    output logic                step_done,
    output logic                overrun
);
    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_ISSUE, S_WAIT, S_WRITE, S_DONE
    } state_t;

    state_t              state_reg;
    logic [AW-1:0]       idx_reg;
    logic                skip_reg;
    logic signed [W-1:0] res_reg;

    logic signed [W-1:0] v_mem [N];
    logic [3:0]          r_mem [N];
    logic signed [W-1:0] i_mem [N];

    // A host write landing on the same edge as the issue latch is forwarded,
    // so the request carries the current the register holds during ISSUE.
    logic signed [W-1:0] i_fwd;
    assign i_fwd = (in_we && (in_addr == idx_reg)) ? in_data : i_mem[idx_reg];

    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            for (int k = 0; k < N; k++) begin
                i_mem[k] <= '0;
            end
        end else if (in_we) begin
            i_mem[in_addr] <= in_data;
        end
    end

    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            state_reg   <= S_IDLE;
            idx_reg     <= '0;
            skip_reg    <= 1'b0;
            res_reg     <= '0;
            dp.dp_valid <= 1'b0;
            dp.dp_idx   <= '0;
            dp.dp_v     <= '0;
            dp.dp_i     <= '0;
            spike_valid <= 1'b0;
            spike_idx   <= '0;
            busy        <= 1'b0;
            step_done   <= 1'b0;
            overrun     <= 1'b0;
            for (int k = 0; k < N; k++) begin
                v_mem[k] <= V_INIT;
                r_mem[k] <= 4'd0;
            end
        end else begin
            spike_valid <= 1'b0;
            step_done   <= 1'b0;
            if (step_start && (state_reg != S_IDLE)) begin
                overrun <= 1'b1;
            end

            case (state_reg)
                S_IDLE: begin
                    if (step_start) begin
                        idx_reg   <= '0;
                        busy      <= 1'b1;
                        state_reg <= S_SELECT;
                    end
                end

                S_SELECT: begin
                    if (r_mem[idx_reg] != 4'd0) begin
                        // Refractory: hold at reset voltage, no datapath trip.
                        r_mem[idx_reg] <= r_mem[idx_reg] - 4'd1;
                        v_mem[idx_reg] <= V_RESET;
                        skip_reg       <= 1'b1;
                        state_reg      <= S_WRITE;
                    end else begin
                        skip_reg    <= 1'b0;
                        dp.dp_valid <= 1'b1;
                        dp.dp_idx   <= idx_reg;
                        dp.dp_v     <= v_mem[idx_reg];
                        dp.dp_i     <= i_fwd;
                        state_reg   <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (dp.dp_ready) begin
                        dp.dp_valid <= 1'b0;
                        state_reg   <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (dp.res_valid) begin
                        res_reg     <= dp.res_v;
                        spike_valid <= (dp.res_v >= V_TH);
                        spike_idx   <= idx_reg;
                        state_reg   <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    if (!skip_reg) begin
                        if (res_reg >= V_TH) begin
                            v_mem[idx_reg] <= V_RESET;
                            r_mem[idx_reg] <= REFRAC;
                        end else begin
                            v_mem[idx_reg] <= res_reg;
                        end
                    end
                    if (idx_reg == AW'(N - 1)) begin
                        step_done <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        idx_reg   <= idx_reg + AW'(1);
                        state_reg <= S_SELECT;
                    end
                end

                S_DONE: begin
                    busy      <= 1'b0;
                    state_reg <= S_IDLE;
                end

                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_sched.sv
// Bench for neuron_sched: emulated datapath, step-level reference model,
// threshold vector table and hand-written multi-cycle sequences.
module tb_neuron_sched;
    localparam int N       = 8;
    localparam int W       = 16;
    localparam int AW      = 3;
    localparam int V_INIT  = -18074;
    localparam int V_TH    = 5120;
    localparam int V_RESET = -18074;
    localparam int REFRAC  = 2;

    logic                emu_clk = 1'b0;
    logic                emu_rst_n = 1'b0;
    logic                step_start = 1'b0;
    logic                in_we = 1'b0;
    logic [AW-1:0]       in_addr = '0;
    logic signed [W-1:0] in_data = '0;
    logic                spike_valid;
    logic [AW-1:0]       spike_idx;
    logic                busy;
    logic                step_done;
    logic                overrun;

    neuron_sched_if #(.N(N), .W(W)) dpif ();

    neuron_sched #(.N(N), .W(W)) dut (
        .emu_clk    (emu_clk),
        .emu_rst_n  (emu_rst_n),
        .step_start (step_start),
        .in_we      (in_we),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .dp         (dpif),
        .spike_valid(spike_valid),
        .spike_idx  (spike_idx),
        .busy       (busy),
        .step_done  (step_done),
        .overrun    (overrun)
    );

    always #5 emu_clk = ~emu_clk;

    typedef struct {int idx; int v; int i;} req_t;
    typedef struct {int idx; int res; int spike; int v_after;} vec_t;

    req_t obs_req[$];
    req_t exp_req[$];
    int   obs_spk[$];
    int   exp_spk[$];
    int   done_cnt = 0;
    int   done_base = 0;
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    int   m_v[N];
    int   m_r[N];
    int   m_i[N];
    bit   force_on[N];
    int   force_val[N];

    int   ready_mode = 0;   // 0 always ready, 1 random, 2 held low
    bit   rand_lat = 1'b0;
    bit   junk = 1'b0;
    int   hold_idx = -1;
    bit   rsp_pending = 1'b0;
    int   rsp_wait = 0;
    int   rsp_val = 0;

    function automatic int wrap(input int x);
        logic signed [W-1:0] t;
        t = W'(x);
        return int'(t);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: handshakes, spikes and step_done sampled on the falling edge.
    initial begin
        req_t r;
        forever begin
            @(negedge emu_clk);
            if (dpif.dp_valid && dpif.dp_ready) begin
                r.idx = int'(dpif.dp_idx);
                r.v   = int'(dpif.dp_v);
                r.i   = int'(dpif.dp_i);
                obs_req.push_back(r);
                $display("step %0d req idx=%0d v=%0d i=%0d", step_no, r.idx, r.v, r.i);
                rsp_val     = force_on[r.idx] ? force_val[r.idx] : wrap(r.v + r.i);
                rsp_wait    = (r.idx == hold_idx) ? 30 : (rand_lat ? int'($urandom_range(0, 3)) : 0);
                rsp_pending = 1'b1;
            end
            if (spike_valid) begin
                obs_spk.push_back(int'(spike_idx));
                $display("step %0d spike idx=%0d", step_no, spike_idx);
            end
            if (step_done) done_cnt++;
        end
    end

    // Emulated datapath: ready policy, result latency, stray results.
    initial begin
        dpif.dp_ready  = 1'b0;
        dpif.res_valid = 1'b0;
        dpif.res_v     = '0;
        forever begin
            @(posedge emu_clk);
            #1;
            dpif.res_valid = 1'b0;
            if (rsp_pending) begin
                if (rsp_wait == 0) begin
                    dpif.res_valid = 1'b1;
                    dpif.res_v     = W'(rsp_val);
                    rsp_pending    = 1'b0;
                end else begin
                    rsp_wait--;
                end
            end else if (junk && ($urandom_range(0, 3) == 0)) begin
                dpif.res_valid = 1'b1;
                dpif.res_v     = W'(V_TH);
            end
            case (ready_mode)
                0:       dpif.dp_ready = 1'b1;
                1:       dpif.dp_ready = ($urandom_range(0, 2) != 0);
                default: dpif.dp_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge emu_clk);
            #1;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_v[k] = V_INIT;
            m_r[k] = 0;
            m_i[k] = 0;
            force_on[k] = 1'b0;
            force_val[k] = 0;
        end
        hold_idx = -1;
    endtask

    task automatic do_reset();
        emu_rst_n = 1'b0;
        rsp_pending = 1'b0;
        model_reset();
        tick(2);
        emu_rst_n = 1'b1;
        tick(1);
    endtask

    task automatic write_i(input int k, input int val);
        in_we   = 1'b1;
        in_addr = AW'(k);
        in_data = W'(val);
        tick(1);
        in_we   = 1'b0;
        m_i[k]  = val;
    endtask

    // One timestep of the neuron rules, applied to the whole population.
    task automatic model_step();
        int nxt;
        req_t r;
        exp_req.delete();
        exp_spk.delete();
        for (int k = 0; k < N; k++) begin
            if (m_r[k] > 0) begin
                m_r[k]--;
                m_v[k] = V_RESET;
            end else begin
                r.idx = k; r.v = m_v[k]; r.i = m_i[k];
                exp_req.push_back(r);
                nxt = force_on[k] ? force_val[k] : wrap(m_v[k] + m_i[k]);
                if (nxt >= V_TH) begin
                    exp_spk.push_back(k);
                    m_v[k] = V_RESET;
                    m_r[k] = REFRAC;
                end else begin
                    m_v[k] = nxt;
                end
            end
        end
    endtask

    task automatic begin_step(input bit use_model);
        if (use_model) model_step();
        obs_req.delete();
        obs_spk.delete();
        done_base = done_cnt;
        step_no++;
        step_start = 1'b1;
        tick(1);
        step_start = 1'b0;
    endtask

    task automatic finish_step(output int cyc);
        cyc = 1;
        while (!step_done && cyc < 4000) begin
            tick(1);
            cyc++;
        end
        chk("step_done_seen", int'(step_done), 1);
        tick(1);
    endtask

    task automatic check_step();
        int n;
        chk("req_count", obs_req.size(), exp_req.size());
        n = (obs_req.size() < exp_req.size()) ? obs_req.size() : exp_req.size();
        for (int j = 0; j < n; j++) begin
            chk("req_idx", obs_req[j].idx, exp_req[j].idx);
            chk("req_v",   obs_req[j].v,   exp_req[j].v);
            chk("req_i",   obs_req[j].i,   exp_req[j].i);
        end
        chk("spike_count", obs_spk.size(), exp_spk.size());
        n = (obs_spk.size() < exp_spk.size()) ? obs_spk.size() : exp_spk.size();
        for (int j = 0; j < n; j++) chk("spike_idx", obs_spk[j], exp_spk[j]);
        chk("done_once", done_cnt - done_base, 1);
        chk("busy_after", int'(busy), 0);
    endtask

    initial begin
        vec_t tab[6];
        int   cyc;
        int   found;
        int   n;
        int   r0;
        int   d0;
        req_t snap;

        tab[0] = '{idx: 3, res: 5120,   spike: 1, v_after: -18074};
        tab[1] = '{idx: 3, res: 5119,   spike: 0, v_after: 5119};
        tab[2] = '{idx: 0, res: 32767,  spike: 1, v_after: -18074};
        tab[3] = '{idx: 7, res: -32768, spike: 0, v_after: -32768};
        tab[4] = '{idx: 5, res: 0,      spike: 0, v_after: 0};
        tab[5] = '{idx: 1, res: 5121,   spike: 1, v_after: -18074};

        // Reset state
        model_reset();
        tick(2);
        chk("rst_busy",      int'(busy), 0);
        chk("rst_step_done", int'(step_done), 0);
        chk("rst_overrun",   int'(overrun), 0);
        chk("rst_spike",     int'(spike_valid), 0);
        chk("rst_dp_valid",  int'(dpif.dp_valid), 0);
        emu_rst_n = 1'b1;
        tick(1);

        // Basic sweep with I=256, minimum latency, then voltage check
        for (int k = 0; k < N; k++) write_i(k, 256);
        begin_step(1);
        finish_step(cyc);
        chk("lat_min", cyc, 4 * N + 1);
        check_step();
        begin_step(1);
        finish_step(cyc);
        check_step();
        foreach (obs_req[j]) chk("v_after_first", obs_req[j].v, -17818);

        // Threshold / refractory vector table
        for (int t = 0; t < 6; t++) begin
            do_reset();
            force_on[tab[t].idx]  = 1'b1;
            force_val[tab[t].idx] = tab[t].res;
            begin_step(0);
            finish_step(cyc);
            chk("tv_spikes", obs_spk.size(), tab[t].spike);
            if (obs_spk.size() > 0) chk("tv_spike_idx", obs_spk[0], tab[t].idx);
            force_on[tab[t].idx] = 1'b0;
            found = -1;
            for (int s = 1; s <= 3; s++) begin
                begin_step(0);
                finish_step(cyc);
                if (s == 1 && tab[t].spike == 1) chk("tv_refrac_lat", cyc, 4 * N - 1);
                if (found < 0) begin
                    foreach (obs_req[j]) begin
                        if (obs_req[j].idx == tab[t].idx) begin
                            found = s;
                            chk("tv_v_after", obs_req[j].v, tab[t].v_after);
                        end
                    end
                end
            end
            chk("tv_issue_step", found, (tab[t].spike == 1) ? 3 : 1);
        end

        // Datapath stall: request fields stable, single handshake, late I write
        do_reset();
        for (int k = 0; k < N; k++) write_i(k, int'($urandom_range(0, 200)));
        ready_mode = 2;
        begin_step(1);
        n = 0;
        while (!dpif.dp_valid && n < 20) begin
            tick(1);
            n++;
        end
        chk("stall_issue", int'(dpif.dp_valid), 1);
        snap.idx = int'(dpif.dp_idx);
        snap.v   = int'(dpif.dp_v);
        snap.i   = int'(dpif.dp_i);
        write_i(0, 77);
        for (int c = 0; c < 10; c++) begin
            @(negedge emu_clk);
            chk("stall_valid", int'(dpif.dp_valid), 1);
            chk("stall_idx", int'(dpif.dp_idx), snap.idx);
            chk("stall_v",   int'(dpif.dp_v),   snap.v);
            chk("stall_i",   int'(dpif.dp_i),   snap.i);
        end
        chk("stall_no_xfer", obs_req.size(), 0);
        tick(1);
        ready_mode = 0;
        finish_step(cyc);
        check_step();
        begin_step(1);
        finish_step(cyc);
        check_step();

        // step_start while busy
        do_reset();
        chk("ovr_init", int'(overrun), 0);
        begin_step(1);
        tick(10);
        step_start = 1'b1;
        tick(1);
        step_start = 1'b0;
        chk("ovr_set", int'(overrun), 1);
        finish_step(cyc);
        check_step();
        tick(60);
        chk("ovr_no_second", obs_req.size(), N);
        chk("ovr_done_total", done_cnt - done_base, 1);
        chk("ovr_sticky", int'(overrun), 1);

        // Reset while waiting on neuron 5; its late result must be discarded
        do_reset();
        for (int k = 0; k < N; k++) write_i(k, 256);
        hold_idx     = 5;
        force_on[5]  = 1'b1;
        force_val[5] = V_TH;
        begin_step(0);
        n = 0;
        while (obs_req.size() < 6 && n < 200) begin
            tick(1);
            n++;
        end
        chk("rst_reach5", obs_req.size(), 6);
        tick(3);
        emu_rst_n = 1'b0;
        tick(1);
        chk("mid_rst_busy",     int'(busy), 0);
        chk("mid_rst_dp_valid", int'(dpif.dp_valid), 0);
        emu_rst_n = 1'b1;
        obs_spk.delete();
        d0 = done_cnt;
        r0 = obs_req.size();
        tick(60);
        chk("late_no_spike", obs_spk.size(), 0);
        chk("late_no_done",  done_cnt - d0, 0);
        chk("late_no_req",   obs_req.size(), r0);
        chk("late_busy",     int'(busy), 0);
        model_reset();
        begin_step(1);
        finish_step(cyc);
        check_step();
        foreach (obs_req[j]) chk("post_rst_v", obs_req[j].v, V_INIT);

        // Randomized sweeps against the reference model
        do_reset();
        ready_mode = 1;
        rand_lat   = 1'b1;
        junk       = 1'b1;
        for (int s = 0; s < 25; s++) begin
            n = int'($urandom_range(0, 3));
            for (int w = 0; w < n; w++)
                write_i(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 1000)) - 300);
            for (int k = 0; k < N; k++) begin
                force_on[k]  = ($urandom_range(0, 3) == 0);
                force_val[k] = V_TH - 1 + int'($urandom_range(0, 2));
            end
            begin_step(1);
            finish_step(cyc);
            check_step();
        end
        ready_mode = 0;
        rand_lat   = 1'b0;
        junk       = 1'b0;
        tick(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
